// File: rtl/fir_sequencer.sv
// fir_sequencer -- control/datapath sequencer for a 4-tap FIR behind an
// AHB-Lite register slave.
//
// Loads four unsigned Q1.15 coefficients from the slave, shifts a 4-deep
// sample delay line on each new sample, then runs one shared multiplier over
// the taps with alternating add/subtract. The final sum is range-checked
// before it is published on fir_out.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   data_ready            slave holds a new sample in sample_data (level)
//   new_coefficient_set   slave holds a new coefficient set (level)
//   sample_data[15:0]     unsigned sample
//   fir_coefficient[15:0] coefficient selected by coefficient_num
//   coefficient_num[1:0]  coefficient index requested from the slave
//   modwait               busy; the slave must not present new work
//   fir_out[15:0]         last valid filter result
//   err                   last result was out of range
//
// Build option:
//   FIR_SATURATE_EN  when defined, out-of-range sums are clamped to
//                    0x0000/0xFFFF and published; ERR is never entered.
module fir_sequencer #(
    parameter int COEF_FRAC = 15,
    parameter int ACC_W     = 20
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        data_ready,
    input  logic        new_coefficient_set,
    input  logic [15:0] sample_data,
    input  logic [15:0] fir_coefficient,
    output logic [1:0]  coefficient_num,
    output logic        modwait,
    output logic [15:0] fir_out,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, MAC, DONE, ERR} state_t;

    state_t                   state;
    logic [3:0][15:0]         coef;
    logic [3:0][15:0]         s;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [1:0]               k;
    logic [31:0]              prod;
    logic [16:0]              term;

    // Single shared multiplier, tap selected by k. The scaled product is
    // truncated to 17 bits before it enters the accumulator.
    always_comb begin
        prod     = 32'(s[k]) * 32'(coef[k]);
        term     = 17'(prod >> COEF_FRAC);
        acc_next = k[0] ? (acc - ACC_W'(term)) : (acc + ACC_W'(term));
    end

`ifdef FIR_SATURATE_EN
    logic [15:0] sat_val;
    always_comb begin
        if (acc[ACC_W-1])
            sat_val = 16'h0000;
        else if (|acc[ACC_W-2:16])
            sat_val = 16'hFFFF;
        else
            sat_val = acc[15:0];
    end
`else
    logic out_of_range;
    assign out_of_range = acc_next[ACC_W-1] | (|acc_next[ACC_W-2:16]);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            coef            <= '0;
            s               <= '0;
            acc             <= '0;
            k               <= '0;
            coefficient_num <= '0;
            modwait         <= 1'b0;
            fir_out         <= '0;
            err             <= 1'b0;
        end else begin
            case (state)
                // Coefficient load wins over a pending sample; the sample is
                // still held by the slave and is picked up afterwards.
                IDLE, ERR: begin
                    if (new_coefficient_set) begin
                        state           <= LOAD;
                        k               <= '0;
                        coefficient_num <= '0;
                        modwait         <= 1'b1;
                        err             <= 1'b0;
                    end else if (data_ready) begin
                        state   <= SHIFT;
                        modwait <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                // coefficient_num runs one step ahead of the capture so the
                // slave presents coef[k] during the cycle it is captured.
                LOAD: begin
                    coef[k] <= fir_coefficient;
                    k       <= k + 2'd1;
                    if (k == 2'd3) begin
                        state           <= IDLE;
                        modwait         <= 1'b0;
                        coefficient_num <= '0;
                    end else begin
                        coefficient_num <= k + 2'd1;
                    end
                end
                SHIFT: begin
                    s     <= {s[2:0], sample_data};
                    acc   <= '0;
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + 2'd1;
                    if (k == 2'd3) begin
`ifdef FIR_SATURATE_EN
                        state <= DONE;
`else
                        if (out_of_range) begin
                            state   <= ERR;
                            modwait <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
`endif
                    end
                end
                DONE: begin
`ifdef FIR_SATURATE_EN
                    fir_out <= sat_val;
`else
                    fir_out <= acc[15:0];
`endif
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: a behavioural FIR model pushes the
// expected result of every sample onto a scoreboard queue; the entry is
// popped and compared once modwait drops.
module tb_fir_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        data_ready = 1'b0;
    logic        new_coefficient_set = 1'b0;
    logic [15:0] sample_data = '0;
    logic [15:0] fir_coefficient;
    logic [1:0]  coefficient_num;
    logic        modwait;
    logic [15:0] fir_out;
    logic        err;

    fir_sequencer dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .data_ready          (data_ready),
        .new_coefficient_set (new_coefficient_set),
        .sample_data         (sample_data),
        .fir_coefficient     (fir_coefficient),
        .coefficient_num     (coefficient_num),
        .modwait             (modwait),
        .fir_out             (fir_out),
        .err                 (err)
    );

    always #5 clk = ~clk;

    // Slave register file: answers the requested coefficient index.
    logic [15:0] slave_coef [4];
    always_comb fir_coefficient = slave_coef[coefficient_num];

    typedef struct {
        logic [15:0] out;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_s [4];
    logic [15:0] m_c [4];
    logic [15:0] m_out;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s[i] = '0;
            m_c[i] = '0;
        end
        m_out = '0;
    endtask

    task automatic model_sample(input logic [15:0] smp);
        longint sum;
        longint t;
        exp_t   e;
        m_s[3] = m_s[2];
        m_s[2] = m_s[1];
        m_s[1] = m_s[0];
        m_s[0] = smp;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            t = (longint'(m_s[i]) * longint'(m_c[i])) >> 15;
            if (i % 2 == 1) sum -= t;
            else            sum += t;
        end
        e.err = 1'b0;
        e.cyc = 6;
        if (sum >= 0 && sum <= 65535) begin
            m_out = sum[15:0];
        end else begin
`ifdef FIR_SATURATE_EN
            m_out = (sum < 0) ? 16'h0000 : 16'hFFFF;
`else
            e.err = 1'b1;
            e.cyc = 5;
`endif
        end
        e.out = m_out;
        sb.push_back(e);
    endtask

    // Called #1 after the edge where modwait first rose; counts busy cycles
    // (bounded) and then compares against the scoreboard head.
    task automatic collect(input string tag);
        int   cnt;
        exp_t e;
        cnt = 1;
        while (modwait && cnt < 20) begin
            @(posedge clk); #1;
            if (modwait) cnt++;
        end
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_busy_cycles"}, cnt, e.cyc);
            check({tag, "_fir_out"}, fir_out, e.out);
            check({tag, "_err"}, err, e.err);
            check({tag, "_coef_num"}, coefficient_num, 0);
        end
    endtask

    task automatic run_sample(input string tag, input logic [15:0] smp);
        model_sample(smp);
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = smp;
        @(posedge clk); #1;
        check({tag, "_busy_start"}, modwait, 1);
        check({tag, "_err_cleared"}, err, 0);
        data_ready = 1'b0;
        collect(tag);
    endtask

    // Drives a coefficient load; with_dr also holds data_ready high so the
    // load-before-sample priority is exercised.
    task automatic load_coefs(input string tag, input logic [15:0] c0, c1, c2, c3,
                              input bit with_dr, input logic [15:0] smp);
        slave_coef[0] = c0; slave_coef[1] = c1;
        slave_coef[2] = c2; slave_coef[3] = c3;
        @(negedge clk);
        new_coefficient_set = 1'b1;
        if (with_dr) begin
            data_ready  = 1'b1;
            sample_data = smp;
        end
        @(posedge clk); #1;
        check({tag, "_ld_busy"}, modwait, 1);
        check({tag, "_ld_num0"}, coefficient_num, 0);
        new_coefficient_set = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check({tag, "_ld_num"}, coefficient_num, i);
            check({tag, "_ld_busy"}, modwait, 1);
        end
        @(posedge clk); #1;
        check({tag, "_ld_idle"}, modwait, 0);
        m_c[0] = c0; m_c[1] = c1; m_c[2] = c2; m_c[3] = c3;
        if (with_dr) begin
            model_sample(smp);
            @(posedge clk); #1;
            check({tag, "_shift_after_load"}, modwait, 1);
            data_ready = 1'b0;
            collect(tag);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 4; i++) slave_coef[i] = '0;

        // Reset state
        #12;
        check("rst_modwait", modwait, 0);
        check("rst_fir_out", fir_out, 0);
        check("rst_err", err, 0);
        check("rst_coef_num", coefficient_num, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // 1: coefficient load sequencing
        load_coefs("t1", 16'h8000, 16'h4000, 16'h2000, 16'h1000, 1'b0, 16'h0);

        // 2: single tap
        load_coefs("t2", 16'h8000, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
        run_sample("t2", 16'd100);
        check("t2_const", fir_out, 16'd100);
        // flush the delay line so the next pattern starts clean
        for (int i = 0; i < 4; i++) run_sample("flush", 16'd0);

        // 3: alternating sum 10,10,20,20
        load_coefs("t3", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 16'h0);
        run_sample("t3a", 16'd10);
        run_sample("t3b", 16'd20);
        run_sample("t3c", 16'd30);
        run_sample("t3d", 16'd40);
        check("t3_const", fir_out, 16'd20);

        // 4: underflow; fir_out holds 20 without saturation
        load_coefs("t4", 16'h0, 16'h8000, 16'h0, 16'h0, 1'b0, 16'h0);
        run_sample("t4a", 16'd5);
        run_sample("t4b", 16'd0);
`ifdef FIR_SATURATE_EN
        check("t4_const", {err, fir_out}, {1'b0, 16'h0000});
`else
        check("t4_const", {err, fir_out}, {1'b1, 16'd20});
`endif
        run_sample("t4c", 16'd0);

        // 5: overflow, then load + sample requested together
        load_coefs("t5", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0);
        run_sample("t5a", 16'hFFFF);
        run_sample("t5b", 16'h0);
        run_sample("t5c", 16'hFFFF);
`ifdef FIR_SATURATE_EN
        check("t5_const", {err, fir_out}, {1'b0, 16'hFFFF});
`else
        check("t5_const", err, 1);
`endif
        load_coefs("t5p", 16'h8000, 16'h0, 16'h0, 16'h0, 1'b1, 16'd3);
        check("t5p_const", fir_out, 16'd3);

        // 6: reset during MAC
        @(negedge clk);
        data_ready  = 1'b1;
        sample_data = 16'd50;
        @(posedge clk); #1;
        data_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("t6_modwait", modwait, 0);
        check("t6_fir_out", fir_out, 0);
        check("t6_err", err, 0);
        check("t6_coef_num", coefficient_num, 0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        run_sample("t6", 16'd1234);
        check("t6_const", fir_out, 16'd0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
